// File: rtl/pipeline_scoreboard.sv
// Hazard scoreboard for the mips_16 pipeline: tracks in-flight destination tags,
// gates ID issue on unresolved RAW hazards and selects per-operand forwarding sources.
module pipeline_scoreboard #(
   parameter int unsigned REG_ADDR_W = 3,
   parameter int unsigned PIPE_DEPTH = 3,
   parameter int unsigned FWD_EN     = 0,
   parameter int unsigned LOAD_STAGE = 1,
   localparam int unsigned FSEL_W    = $clog2(PIPE_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_src1,
   input  logic [REG_ADDR_W-1:0] issue_src2,
   input  logic                  issue_src1_used,
   input  logic                  issue_src2_used,
   input  logic [REG_ADDR_W-1:0] issue_dest,
   input  logic                  issue_dest_wr,
   input  logic                  issue_is_load,
   output logic                  issue_ready,
   output logic [FSEL_W-1:0]     fwd_sel1,
   output logic [FSEL_W-1:0]     fwd_sel2,
   output logic [PIPE_DEPTH-1:0] stage_valid,
   output logic [15:0]           stall_count
);

   logic [PIPE_DEPTH-1:0] valid_q;
   logic [PIPE_DEPTH-1:0] load_q;
   logic [REG_ADDR_W-1:0] dest_q [PIPE_DEPTH];
   logic [15:0]           stall_cnt_q;

   logic [FSEL_W:0] res1, res2;
   logic            push;

   // Returns {hazard, fwd_sel}. Scanning oldest to youngest lets the youngest match win.
   function automatic logic [FSEL_W:0] resolve(input logic [REG_ADDR_W-1:0] src,
                                               input logic                  used);
      logic            hit;
      logic            ld;
      int unsigned     idx;
      logic            haz;
      logic [FSEL_W-1:0] sel;
      hit = 1'b0;
      ld  = 1'b0;
      idx = 0;
      haz = 1'b0;
      sel = '0;
      for (int k = int'(PIPE_DEPTH) - 1; k >= 0; k--) begin
         if (valid_q[k] && (dest_q[k] == src)) begin
            hit = 1'b1;
            ld  = load_q[k];
            idx = k;
         end
      end
      if (issue_valid && used && (src != '0) && hit) begin
         if (FWD_EN == 0) begin
            haz = 1'b1;
         end else if (!ld || (idx >= LOAD_STAGE)) begin
            sel = FSEL_W'(idx + 1);
         end else begin
            haz = 1'b1;
         end
      end
      return {haz, sel};
   endfunction

   always_comb begin
      res1 = resolve(issue_src1, issue_src1_used);
      res2 = resolve(issue_src2, issue_src2_used);
   end

   assign issue_ready = !(res1[FSEL_W] || res2[FSEL_W]);
   assign fwd_sel1    = res1[FSEL_W-1:0];
   assign fwd_sel2    = res2[FSEL_W-1:0];
   assign stage_valid = valid_q;
   assign stall_count = stall_cnt_q;

   // A stalled or non-writing cycle pushes a bubble; older tags drain regardless.
   assign push = issue_valid && issue_ready && issue_dest_wr && (issue_dest != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= '0;
         load_q      <= '0;
         stall_cnt_q <= '0;
         for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
            dest_q[k] <= '0;
         end
      end else begin
         for (int k = int'(PIPE_DEPTH) - 1; k > 0; k--) begin
            valid_q[k] <= valid_q[k-1];
            load_q[k]  <= load_q[k-1];
            dest_q[k]  <= dest_q[k-1];
         end
         valid_q[0] <= push;
         load_q[0]  <= issue_is_load;
         dest_q[0]  <= issue_dest;
         if (issue_valid && !issue_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Bench for pipeline_scoreboard: directed scenarios plus randomized traffic checked against
// a timestamp-based model of in-flight writes, on stall-only, forwarding and deep variants.
module tb_pipeline_scoreboard;

   localparam int LOAD_STAGE = 1;

   logic       clk, rst;
   logic       iv, u1, u2, dw, ld;
   logic [2:0] s1, s2, d;

   logic        rdy_s, rdy_f, rdy_d;
   logic [1:0]  f1_s, f2_s, f1_f, f2_f;
   logic [3:0]  f1_d, f2_d;
   logic [2:0]  sv_s, sv_f;
   logic [14:0] sv_d;
   logic [15:0] sc_s, sc_f, sc_d;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: writes recorded by issue cycle; a write from cycle t sits in stage now-t-1.
   int now;
   bit w_valid [2][4];
   int w_cyc   [2][4];
   int w_dest  [2][4];
   bit w_ld    [2][4];

   pipeline_scoreboard #(.FWD_EN(0)) dut_s (
      .clk(clk), .rst(rst), .issue_valid(iv), .issue_src1(s1), .issue_src2(s2),
      .issue_src1_used(u1), .issue_src2_used(u2), .issue_dest(d), .issue_dest_wr(dw),
      .issue_is_load(ld), .issue_ready(rdy_s), .fwd_sel1(f1_s), .fwd_sel2(f2_s),
      .stage_valid(sv_s), .stall_count(sc_s)
   );

   pipeline_scoreboard #(.FWD_EN(1), .LOAD_STAGE(LOAD_STAGE)) dut_f (
      .clk(clk), .rst(rst), .issue_valid(iv), .issue_src1(s1), .issue_src2(s2),
      .issue_src1_used(u1), .issue_src2_used(u2), .issue_dest(d), .issue_dest_wr(dw),
      .issue_is_load(ld), .issue_ready(rdy_f), .fwd_sel1(f1_f), .fwd_sel2(f2_f),
      .stage_valid(sv_f), .stall_count(sc_f)
   );

   pipeline_scoreboard #(.PIPE_DEPTH(15), .FWD_EN(0)) dut_d (
      .clk(clk), .rst(rst), .issue_valid(iv), .issue_src1(s1), .issue_src2(s2),
      .issue_src1_used(u1), .issue_src2_used(u2), .issue_dest(d), .issue_dest_wr(dw),
      .issue_is_load(ld), .issue_ready(rdy_d), .fwd_sel1(f1_d), .fwd_sel2(f2_d),
      .stage_valid(sv_d), .stall_count(sc_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_in(input logic v, input logic [2:0] a, input logic ua,
                         input logic [2:0] b, input logic ub, input logic [2:0] dd,
                         input logic w, input logic l);
      iv = v; s1 = a; u1 = ua; s2 = b; u2 = ub; d = dd; dw = w; ld = l;
   endtask

   task automatic do_reset();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic void model_eval(input int m, input logic [2:0] src, input logic used,
                                      output bit haz, output int sel);
      int slot;
      haz = 0;
      sel = 0;
      if (!iv || !used || src == 0) return;
      for (int a = 1; a <= 3; a++) begin
         slot = (now - a) & 3;
         if (now >= a && w_valid[m][slot] && w_cyc[m][slot] == now - a &&
             w_dest[m][slot] == int'(src)) begin
            if (m == 0) haz = 1;
            else if (!w_ld[m][slot] || a - 1 >= LOAD_STAGE) sel = a;
            else haz = 1;
            return;
         end
      end
   endfunction

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++;
      if ({rdy_s, rdy_f, rdy_d} !== 3'b111) begin
         n_fail++; $display("FAIL reset_ready: got %b expected 111", {rdy_s, rdy_f, rdy_d});
      end
      n_checks++;
      if ({f1_s, f2_s, f1_f, f2_f} !== 8'h00) begin
         n_fail++; $display("FAIL reset_fwd: got %h expected 00", {f1_s, f2_s, f1_f, f2_f});
      end
      n_checks++;
      if ({sv_s, sv_f} !== 6'b0 || sv_d !== 15'b0) begin
         n_fail++; $display("FAIL reset_stage_valid: got %b %b %h expected 0", sv_s, sv_f, sv_d);
      end
      n_checks++;
      if (sc_s !== 16'd0 || sc_f !== 16'd0) begin
         n_fail++; $display("FAIL reset_stall_count: got %0d %0d expected 0", sc_s, sc_f);
      end
   endtask

   task automatic test_stall_raw();
      do_reset();
      set_in(1, 0, 0, 0, 0, 3, 1, 0);
      #1;
      n_checks++;
      if (rdy_s !== 1'b1) begin
         n_fail++; $display("FAIL raw_producer_ready: got %b expected 1", rdy_s);
      end
      @(negedge clk);
      set_in(1, 3, 1, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         #1;
         n_checks++;
         if (rdy_s !== (i == 4)) begin
            n_fail++; $display("FAIL raw_stall_cycle%0d: got %b expected %b", i, rdy_s, i == 4);
         end
         if (i == 1) begin
            n_checks++;
            if (sv_s !== 3'b001) begin
               n_fail++; $display("FAIL raw_stage_valid: got %b expected 001", sv_s);
            end
         end
         @(negedge clk);
      end
      iv = 1'b0;
      #1;
      n_checks++;
      if (sc_s !== 16'd3) begin
         n_fail++; $display("FAIL raw_stall_count: got %0d expected 3", sc_s);
      end
   endtask

   task automatic test_reg0_unused();
      do_reset();
      set_in(1, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      set_in(1, 0, 1, 0, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (sv_s !== 3'b000 || rdy_s !== 1'b1) begin
         n_fail++; $display("FAIL reg0: got sv=%b rdy=%b expected sv=000 rdy=1", sv_s, rdy_s);
      end
      @(negedge clk);
      set_in(1, 0, 0, 0, 0, 3, 1, 0);
      @(negedge clk);
      set_in(1, 6, 1, 3, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (rdy_s !== 1'b1) begin
         n_fail++; $display("FAIL unused_src2: got %b expected 1", rdy_s);
      end
      set_in(1, 5, 1, 0, 0, 5, 1, 0);
      #1;
      n_checks++;
      if (rdy_s !== 1'b1) begin
         n_fail++; $display("FAIL self_dest: got %b expected 1", rdy_s);
      end
   endtask

   task automatic test_forward();
      for (int gap = 0; gap <= 2; gap++) begin
         do_reset();
         set_in(1, 0, 0, 0, 0, 2, 1, 0);
         @(negedge clk);
         for (int g = 0; g < gap; g++) begin
            set_in(1, 0, 0, 0, 0, 6, 1, 0);
            @(negedge clk);
         end
         set_in(1, 2, 1, 2, 1, 0, 0, 0);
         #1;
         n_checks++;
         if (rdy_f !== 1'b1 || f1_f !== 2'(gap + 1) || f2_f !== 2'(gap + 1)) begin
            n_fail++;
            $display("FAIL forward_gap%0d: got rdy=%b sel=%0d/%0d expected rdy=1 sel=%0d",
                     gap, rdy_f, f1_f, f2_f, gap + 1);
         end
         n_checks++;
         if (rdy_s !== 1'b0 || f1_s !== 2'd0 || f2_s !== 2'd0) begin
            n_fail++;
            $display("FAIL stall_mode_gap%0d: got rdy=%b sel=%0d/%0d expected rdy=0 sel=0",
                     gap, rdy_s, f1_s, f2_s);
         end
      end
   endtask

   task automatic test_load_use();
      do_reset();
      set_in(1, 0, 0, 0, 0, 4, 1, 1);
      @(negedge clk);
      set_in(1, 4, 1, 0, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (rdy_f !== 1'b0 || f1_f !== 2'd0) begin
         n_fail++; $display("FAIL load_use_stall: got rdy=%b sel=%0d expected 0 0", rdy_f, f1_f);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (rdy_f !== 1'b1 || f1_f !== 2'd2 || sc_f !== 16'd1) begin
         n_fail++;
         $display("FAIL load_use_issue: got rdy=%b sel=%0d cnt=%0d expected 1 2 1",
                  rdy_f, f1_f, sc_f);
      end
   endtask

   task automatic test_youngest();
      do_reset();
      set_in(1, 0, 0, 0, 0, 5, 1, 0);
      @(negedge clk);
      @(negedge clk);
      set_in(1, 5, 1, 0, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (f1_f !== 2'd1 || rdy_f !== 1'b1) begin
         n_fail++; $display("FAIL youngest: got sel=%0d rdy=%b expected 1 1", f1_f, rdy_f);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_in(1, 0, 0, 0, 0, 3, 1, 0);
      @(negedge clk);
      set_in(1, 3, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      n_checks++;
      if (rdy_s !== 1'b0) begin
         n_fail++; $display("FAIL mid_stall_pre: got %b expected 0", rdy_s);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (rdy_s !== 1'b1 || sv_s !== 3'b000 || sc_s !== 16'd0) begin
         n_fail++;
         $display("FAIL mid_stall_reset: got rdy=%b sv=%b cnt=%0d expected 1 000 0",
                  rdy_s, sv_s, sc_s);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_saturate();
      do_reset();
      // Self-dependent instruction: issues, then stalls until its own tag drains.
      set_in(1, 3, 1, 0, 0, 3, 1, 0);
      repeat (16) @(negedge clk);
      #1;
      n_checks++;
      if (sc_d !== 16'd15) begin
         n_fail++; $display("FAIL deep_stall_count: got %0d expected 15", sc_d);
      end
      repeat (70000 - 16) @(negedge clk);
      #1;
      n_checks++;
      if (sc_d !== 16'hFFFF) begin
         n_fail++; $display("FAIL saturate: got %h expected ffff", sc_d);
      end
      n_checks++;
      if (sc_s !== 16'd52500 || sc_f !== 16'd0) begin
         n_fail++; $display("FAIL long_counts: got %0d %0d expected 52500 0", sc_s, sc_f);
      end
   endtask

   task automatic test_random();
      bit         h1, h2, er;
      int         e1, e2, exp_sc [2], slot, a;
      logic [2:0] exp_sv, o_sv;
      logic [1:0] o_f1, o_f2;
      logic       o_rdy;
      logic [15:0] o_sc;
      do_reset();
      now = 0;
      for (int m = 0; m < 2; m++) begin
         exp_sc[m] = 0;
         for (int j = 0; j < 4; j++) w_valid[m][j] = 0;
      end
      for (int i = 0; i < 400; i++) begin
         set_in(($urandom_range(3) != 0), 3'($urandom_range(7)), 1'($urandom_range(1)),
                3'($urandom_range(7)), 1'($urandom_range(1)), 3'($urandom_range(7)),
                ($urandom_range(3) != 0), 1'($urandom_range(1)));
         #1;
         for (int m = 0; m < 2; m++) begin
            model_eval(m, s1, u1, h1, e1);
            model_eval(m, s2, u2, h2, e2);
            er = !(h1 || h2);
            exp_sv = '0;
            for (a = 1; a <= 3; a++) begin
               slot = (now - a) & 3;
               if (now >= a && w_valid[m][slot] && w_cyc[m][slot] == now - a) exp_sv[a-1] = 1'b1;
            end
            o_rdy = (m == 0) ? rdy_s : rdy_f;
            o_f1  = (m == 0) ? f1_s : f1_f;
            o_f2  = (m == 0) ? f2_s : f2_f;
            o_sv  = (m == 0) ? sv_s : sv_f;
            o_sc  = (m == 0) ? sc_s : sc_f;
            n_checks++;
            if (o_rdy !== er || o_f1 !== 2'(e1) || o_f2 !== 2'(e2) || o_sv !== exp_sv ||
                o_sc !== 16'(exp_sc[m])) begin
               n_fail++;
               $display("FAIL random_m%0d_c%0d: got rdy=%b sel=%0d/%0d sv=%b cnt=%0d expected rdy=%b sel=%0d/%0d sv=%b cnt=%0d",
                        m, i, o_rdy, o_f1, o_f2, o_sv, o_sc, er, e1, e2, exp_sv, exp_sc[m]);
            end
            if (iv && !er && exp_sc[m] < 65535) exp_sc[m]++;
            slot = now & 3;
            w_valid[m][slot] = iv && er && dw && (d != 0);
            w_cyc[m][slot]   = now;
            w_dest[m][slot]  = int'(d);
            w_ld[m][slot]    = ld;
         end
         @(negedge clk);
         now++;
      end
   endtask

   initial begin
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_stall_raw();
      test_reg0_unused();
      test_forward();
      test_load_use();
      test_youngest();
      test_reset_mid_stall();
      test_random();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
